// File: rtl/vga_sprite_pkg.sv
// Shared arbiter definitions for the sprite ROM path: state encoding,
// default sizes and the requester-ID width helper.
package vga_sprite_pkg;
  localparam int NREQ_DEF      = 4;
  localparam int AW_DEF        = 15;
  localparam int DW_DEF        = 8;
  localparam int ROM_LAT_DEF   = 1;
  localparam int MAX_BURST_DEF = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin search: first set bit of req at or after start, wrapping at NREQ.
module rr_pick
  import vga_sprite_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = ID_W_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  idx
);
  // Walk from the far end so the closest hit to start is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % NREQ]) begin
        found = 1'b1;
        idx   = IDW'((int'(start) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Burst-limited round-robin arbiter in front of a single-port sprite ROM.
// Define SPRITE_ARB_PRIO0_EN to let requester 0 preempt any owner.
module sprite_rom_arbiter
  import vga_sprite_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int ROM_LAT   = ROM_LAT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr_in,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_dout,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              busy
);
  localparam int IDW = id_w(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_e                state, nxt_state;
  logic [IDW-1:0]            owner, nxt_owner, last_owner, start, gnt_id, pick_idx;
  logic [CW-1:0]             burst_cnt, nxt_cnt;
  logic                      pick_found, gnt_vld, others, keep;
  logic [AW-1:0]             addr_q;
  logic [ROM_LAT:0]          vld_pipe;
  logic [ROM_LAT:0][IDW-1:0] id_pipe;

  // last_owner always equals the current owner while in OWN, so one
  // picker starting at last_owner+1 serves both IDLE and hand-off.
  assign start = (last_owner == IDW'(NREQ - 1)) ? '0 : last_owner + 1'b1;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_cnt   = burst_cnt;
    gnt_vld   = 1'b0;
    gnt_id    = owner;
    others    = |(req & ~(NREQ'(1) << owner));
    keep      = (state == ARB_OWN) && req[owner] && ((burst_cnt < CNT_MAX) || !others);
`ifdef SPRITE_ARB_PRIO0_EN
    if (req[0]) begin
      gnt_vld = 1'b1;
      gnt_id  = '0;
    end else
`endif
    if (keep) begin
      gnt_vld = 1'b1;
      gnt_id  = owner;
    end else if (pick_found) begin
      gnt_vld = 1'b1;
      gnt_id  = pick_idx;
    end
    if (gnt_vld) begin
      nxt_state = ARB_OWN;
      nxt_owner = gnt_id;
      if (state == ARB_OWN && gnt_id == owner)
        nxt_cnt = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + 1'b1;
      else
        nxt_cnt = CW'(1);
    end else begin
      nxt_state = ARB_IDLE;
      nxt_cnt   = '0;
    end
    // Grant must vanish the moment reset asserts, not at the next edge.
    if (!rst) gnt_vld = 1'b0;
  end

  assign gnt      = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
  assign rom_addr = gnt_vld ? addr_in[gnt_id*AW +: AW] : addr_q;
  assign rvalid   = vld_pipe[ROM_LAT] ? (NREQ'(1) << id_pipe[ROM_LAT]) : '0;
  assign busy     = gnt_vld | (|vld_pipe);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      burst_cnt  <= '0;
      last_owner <= IDW'(NREQ - 1);
      addr_q     <= '0;
      vld_pipe   <= '0;
      id_pipe    <= '0;
      rdata      <= '0;
    end else begin
      state     <= nxt_state;
      owner     <= nxt_owner;
      burst_cnt <= nxt_cnt;
      if (gnt_vld) begin
        last_owner <= gnt_id;
        addr_q     <= rom_addr;
      end
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], gnt_vld};
      id_pipe  <= {id_pipe[ROM_LAT-1:0], gnt_id};
      // ROM data for a grant is on rom_dout while it sits in stage ROM_LAT-1.
      if (vld_pipe[ROM_LAT-1]) rdata <= rom_dout;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a latency-modelled ROM.
module tb_sprite_rom_arbiter;
  localparam int NREQ = 4, AW = 15, DW = 8, ROM_LAT = 1, MB = 4;
  localparam int BOUND = (NREQ - 1) * MB + 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][AW-1:0]   addr_v;
  logic [NREQ-1:0]           gnt, rvalid;
  logic [AW-1:0]             rom_addr;
  logic [DW-1:0]             rom_dout, rdata;
  logic                      busy;
  logic [DW-1:0]             rom_q [ROM_LAT];

  typedef struct {int due; int id; logic [DW-1:0] data;} sb_t;
  sb_t sb[$];

  bit             m_own;
  int             m_owner, m_cnt, m_last;
  logic [AW-1:0]  m_addr;
  int             cyc, nvec, nerr;
  int             waitc [NREQ];

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_v), .gnt(gnt), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .rvalid(rvalid), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    rom_q[0] <= rom_fn(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign rom_dout = rom_q[ROM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 1'b0; m_owner = 0; m_cnt = 0; m_last = NREQ - 1; m_addr = '0;
    sb.delete();
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
  endtask

  // Reference arbitration decision for the current cycle; -1 = no grant.
  function automatic int pick();
`ifdef SPRITE_ARB_PRIO0_EN
    if (req[0]) return 0;
`endif
    if (m_own && req[m_owner] && (m_cnt < MB || (req & ~(4'b0001 << m_owner)) == '0))
      return m_owner;
    for (int k = 1; k <= NREQ; k++)
      if (req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  // One clock cycle: inputs already driven after a negedge.
  task automatic step();
    int g;
    logic [NREQ-1:0] eg;
    logic [AW-1:0] ea;
    #1;
    g  = pick();
    eg = (g >= 0) ? (4'b0001 << g) : '0;
    ea = (g >= 0) ? addr_v[g] : m_addr;
    chk("gnt", gnt, eg);
    chk("onehot", $onehot0(gnt), 1);
    chk("gnt_req", gnt & ~req, 0);
    chk("rom_addr", rom_addr, ea);
    chk("busy", busy, (g >= 0 || sb.size() > 0));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rvalid", rvalid, 1 << sb[0].id);
      chk("rdata", rdata, sb[0].data);
      void'(sb.pop_front());
    end else begin
      chk("rvalid_idle", rvalid, 0);
    end
`ifndef SPRITE_ARB_PRIO0_EN
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !gnt[i]) waitc[i]++;
      else waitc[i] = 0;
      if (waitc[i] > BOUND) chk("wait_bound", waitc[i], BOUND);
    end
`endif
    if (g >= 0) begin
      sb.push_back('{cyc + ROM_LAT + 1, g, rom_fn(addr_v[g])});
      m_cnt   = (m_own && g == m_owner) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
      m_own   = 1'b1;
      m_owner = g;
      m_last  = g;
      m_addr  = addr_v[g];
    end else begin
      m_own = 1'b0;
      m_cnt = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    repeat (n) @(negedge clk);
    cyc += n;
    rst = 1'b1;
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    addr_v = '0; req = '0;
    model_reset();
    @(negedge clk);
    req = '1;
    do_reset(2);

    // Single read: grant and address in T, data two cycles later.
    req = 4'b0001; addr_v[0] = 15'h0064;
    #1;
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_addr", rom_addr, 15'h0064);
    step();
    req = '0;
    step();
    chk("t1_rvalid", rvalid, 4'b0001);
    chk("t1_rdata", rdata, 8'h3E);
    step(); step();

    // All requesting: bursts of MAX_BURST in index order, no gaps.
    do_reset(1);
    req = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
`ifdef SPRITE_ARB_PRIO0_EN
      chk("t2_seq", gnt, 4'b0001);
`else
      chk("t2_seq", gnt, 4'b0001 << (k / 4));
`endif
      step();
    end
    req = '0;
    repeat (3) step();

    // Owner drops after two grants: hand-off the next cycle, fresh burst count.
    do_reset(1);
    req = 4'b0110;
    #1; chk("t3_g0", gnt, 4'b0010); step();
    #1; chk("t3_g1", gnt, 4'b0010); step();
    req = 4'b0100;
    #1; chk("t3_handoff", gnt, 4'b0100); step();
    step(); step();
    req = 4'b0110;
    #1; chk("t3_burst4", gnt, 4'b0100); step();
    #1; chk("t3_switch", gnt, 4'b0010); step();
    req = '0;
    step();

    // Reset with two reads in flight: nothing comes back, requester 0 first.
    req = 4'b0011;
    step(); step();
    chk("t4_busy", busy, 1);
    do_reset(1);
    req = '0;
    for (int k = 0; k < 4; k++) begin
      #1; chk("t4_rvalid", rvalid, 0);
      step();
    end
    req = '1;
    #1; chk("t4_first", gnt, 4'b0001);
    step();
    req = '0;
    repeat (3) step();

`ifdef SPRITE_ARB_PRIO0_EN
    // Requester 0 preempts a mid-burst owner, which then resumes.
    do_reset(1);
    req = 4'b0100;
    repeat (2) step();
    req = 4'b0101;
    #1; chk("p_preempt", gnt, 4'b0001); step();
    step();
    req = 4'b0100;
    #1; chk("p_resume", gnt, 4'b0100); step();
    req = '0;
    repeat (3) step();
`endif

    // Random traffic with sticky requests so bursts actually build up.
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        addr_v[i] = AW'($urandom);
      end
      step();
    end
    req = '0;
    repeat (ROM_LAT + 3) step();
    chk("drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
